// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use / freeze hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } state_t;

    localparam int REG_ZERO = 0;

    // Countdown width able to hold LOAD_LAT-1 with headroom.
    function automatic int cnt_width(input int load_lat);
        return $clog2(load_lat) + 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register load countdown array.
// Entries set on an advancing load, decrement while advancing, and hold during a freeze.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic [REG_AW-1:0] rd1_addr,
    input  logic [REG_AW-1:0] rd2_addr,
    output logic              busy1,
    output logic              busy2
);

    localparam int N     = 2 ** REG_AW;
    localparam int CNT_W = cnt_width(LOAD_LAT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LOAD_LAT - 1);

    logic [CNT_W-1:0] cnt [N];

    // A set on the same entry overrides that entry's decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else if (advance) begin
            for (int i = 0; i < N; i++) begin
                if (set_en && (set_addr == REG_AW'(i))) begin
                    cnt[i] <= RELOAD;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    assign busy1 = (cnt[rd1_addr] != '0);
    assign busy2 = (cnt[rd2_addr] != '0);

endmodule

// File: rtl/hazard_unit_mc.sv
// Load-use and pipeline-freeze controller with configurable load latency and freeze watchdog.
// Define HAZ_PERF_EN to add the stall/freeze/flush event counters.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int WDT_W     = 8,
    parameter int WDT_LIMIT = 200
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] RS1addr_i,
    input  logic [REG_AW-1:0] RS2addr_i,
    input  logic              RS1use_i,
    input  logic              RS2use_i,
    input  logic              EX_MemRead_i,
    input  logic [REG_AW-1:0] EX_RDaddr_i,
    input  logic              MemBusy_i,
    input  logic              BranchTaken_i,
    output logic              NoOp_o,
    output logic              Stall_o,
    output logic              PCWrite_o,
    output logic              Flush_o,
    output logic              Freeze_o,
    output logic              Timeout_o,
`ifdef HAZ_PERF_EN
    output logic [31:0]       LuStallCnt_o,
    output logic [31:0]       FreezeCnt_o,
    output logic [31:0]       FlushCnt_o,
`endif
    output state_t            State_o
);

    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

    state_t           state;
    logic [WDT_W-1:0] wdt;
    logic [WDT_W-1:0] wdt_next;
    logic             timeout;
    logic             ex_load;
    logic             sb_busy1;
    logic             sb_busy2;
    logic             hit1;
    logic             hit2;
    logic             lu;

    assign ex_load = EX_MemRead_i && (EX_RDaddr_i != ZERO);

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .advance  (!MemBusy_i),
        .set_en   (ex_load),
        .set_addr (EX_RDaddr_i),
        .rd1_addr (RS1addr_i),
        .rd2_addr (RS2addr_i),
        .busy1    (sb_busy1),
        .busy2    (sb_busy2)
    );

    assign hit1 = RS1use_i && (RS1addr_i != ZERO) &&
                  ((ex_load && (EX_RDaddr_i == RS1addr_i)) || sb_busy1);
    assign hit2 = RS2use_i && (RS2addr_i != ZERO) &&
                  ((ex_load && (EX_RDaddr_i == RS2addr_i)) || sb_busy2);
    assign lu   = hit1 || hit2;

    // Reset gates every control so an asserted reset releases the pipeline at once.
    always_comb begin
        NoOp_o    = 1'b0;
        Stall_o   = 1'b0;
        PCWrite_o = 1'b1;
        Flush_o   = 1'b0;
        Freeze_o  = 1'b0;
        if (rst_i) begin
            if (MemBusy_i) begin
                Freeze_o  = 1'b1;
                Stall_o   = 1'b1;
                PCWrite_o = 1'b0;
            end else if (lu) begin
                NoOp_o    = 1'b1;
                Stall_o   = 1'b1;
                PCWrite_o = 1'b0;
            end else if (BranchTaken_i) begin
                Flush_o   = 1'b1;
            end
        end
    end

    assign wdt_next = MemBusy_i ? ((wdt == '1) ? wdt : wdt + 1'b1) : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= RUN;
            wdt     <= '0;
            timeout <= 1'b0;
        end else begin
            state <= MemBusy_i ? FREEZE : RUN;
            wdt   <= wdt_next;
            if (int'(wdt_next) >= WDT_LIMIT) begin
                timeout <= 1'b1;
            end
        end
    end

    assign Timeout_o = timeout;
    assign State_o   = state;

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            LuStallCnt_o <= '0;
            FreezeCnt_o  <= '0;
            FlushCnt_o   <= '0;
        end else begin
            if (MemBusy_i) begin
                FreezeCnt_o <= FreezeCnt_o + 32'd1;
            end else if (lu) begin
                LuStallCnt_o <= LuStallCnt_o + 32'd1;
            end else if (BranchTaken_i) begin
                FlushCnt_o <= FlushCnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two instances (LOAD_LAT=1 and LOAD_LAT=3) share one stimulus stream.
module tb_hazard_unit_mc;
    import hazard_pkg::*;

    logic       clk;
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       ld;
    logic [4:0] rd;
    logic       busy;
    logic       br;

    logic   n1, s1, p1, f1, z1, t1;
    logic   n3, s3, p3, f3, z3, t3;
    state_t st1, st3;
`ifdef HAZ_PERF_EN
    logic [31:0] lc1, fc1, xc1, lc3, fc3, xc3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    hazard_unit_mc #(.REG_AW(5), .LOAD_LAT(1), .WDT_W(8), .WDT_LIMIT(200)) dut1 (
        .clk_i(clk), .rst_i(rst), .RS1addr_i(rs1), .RS2addr_i(rs2),
        .RS1use_i(u1), .RS2use_i(u2), .EX_MemRead_i(ld), .EX_RDaddr_i(rd),
        .MemBusy_i(busy), .BranchTaken_i(br),
        .NoOp_o(n1), .Stall_o(s1), .PCWrite_o(p1), .Flush_o(f1), .Freeze_o(z1),
        .Timeout_o(t1),
`ifdef HAZ_PERF_EN
        .LuStallCnt_o(lc1), .FreezeCnt_o(fc1), .FlushCnt_o(xc1),
`endif
        .State_o(st1)
    );

    hazard_unit_mc #(.REG_AW(5), .LOAD_LAT(3), .WDT_W(8), .WDT_LIMIT(200)) dut3 (
        .clk_i(clk), .rst_i(rst), .RS1addr_i(rs1), .RS2addr_i(rs2),
        .RS1use_i(u1), .RS2use_i(u2), .EX_MemRead_i(ld), .EX_RDaddr_i(rd),
        .MemBusy_i(busy), .BranchTaken_i(br),
        .NoOp_o(n3), .Stall_o(s3), .PCWrite_o(p3), .Flush_o(f3), .Freeze_o(z3),
        .Timeout_o(t3),
`ifdef HAZ_PERF_EN
        .LuStallCnt_o(lc3), .FreezeCnt_o(fc3), .FlushCnt_o(xc3),
`endif
        .State_o(st3)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a register is pending while fewer advancing cycles
    // have elapsed than its load latency since the load advanced out of EX.
    int unsigned adv_cnt;
    int unsigned ready1 [32];
    int unsigned ready3 [32];
    int unsigned busy_run;
    bit          timeout_m;
    bit          frozen_m;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            adv_cnt   = 0;
            busy_run  = 0;
            timeout_m = 0;
            frozen_m  = 0;
            for (int i = 0; i < 32; i++) begin
                ready1[i] = 0;
                ready3[i] = 0;
            end
        end else begin
            if (!busy) begin
                if (ld && rd != 5'd0) begin
                    ready1[rd] = adv_cnt + 1;
                    ready3[rd] = adv_cnt + 3;
                end
                adv_cnt = adv_cnt + 1;
            end
            busy_run = busy ? ((busy_run < 255) ? busy_run + 1 : 255) : 0;
            if (busy_run >= 200) timeout_m = 1;
            frozen_m = busy;
        end
    end

    // {NoOp, Stall, PCWrite, Flush, Freeze}
    function automatic logic [4:0] exp_out(input bit pend1, input bit pend2);
        bit h1, h2;
        h1 = u1 && rs1 != 5'd0 && ((ld && rd == rs1) || pend1);
        h2 = u2 && rs2 != 5'd0 && ((ld && rd == rs2) || pend2);
        if (!rst)          return 5'b00100;
        if (busy)          return 5'b01001;
        if (h1 || h2)      return 5'b11000;
        if (br)            return 5'b00110;
        return 5'b00100;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare on every cycle
    always @(negedge clk) begin
        check("dut1_outs", {27'd0, n1, s1, p1, f1, z1},
              {27'd0, exp_out(adv_cnt < ready1[rs1], adv_cnt < ready1[rs2])});
        check("dut3_outs", {27'd0, n3, s3, p3, f3, z3},
              {27'd0, exp_out(adv_cnt < ready3[rs1], adv_cnt < ready3[rs2])});
        check("dut1_timeout", {31'd0, t1}, {31'd0, timeout_m});
        check("dut3_timeout", {31'd0, t3}, {31'd0, timeout_m});
        check("dut1_state", {31'd0, st1}, {31'd0, frozen_m});
        check("dut3_state", {31'd0, st3}, {31'd0, frozen_m});
    end

    // Driver tasks
    task automatic set_in(input logic l, input logic [4:0] d, input logic [4:0] a1, input logic e1,
                          input logic [4:0] a2, input logic e2, input logic b, input logic t);
        ld = l; rd = d; rs1 = a1; u1 = e1; rs2 = a2; u2 = e2; busy = b; br = t;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0);
            next_cycle();
        end
    endtask

    task automatic load_consume(input int gap, output int c1, output int c3);
        bit cons;
        c1 = 0;
        c3 = 0;
        for (int c = 0; c < 12; c++) begin
            cons = (c >= gap);
            set_in(c == 0, 5'd7, 0, 0, 5'd7, cons, 0, 0);
            @(negedge clk);
            if (cons && s1) c1++;
            if (cons && s3) c3++;
            next_cycle();
        end
    endtask

    int c1, c3;

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("reset_outs", {27'd0, n1, s1, p1, f1, z1}, 32'h04);
        check("reset_timeout", {31'd0, t1}, 32'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // One-bubble EX compare
        set_in(1, 5'd5, 5'd5, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("lat1_bubble", {27'd0, n1, s1, p1, f1, z1}, 32'h18);
        next_cycle();
        set_in(0, 0, 5'd5, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("lat1_clear", {27'd0, n1, s1, p1, f1, z1}, 32'h04);
        next_cycle();
        idle(4);
        set_in(1, 5'd5, 5'd5, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("nouse_lat1", {27'd0, n1, s1, p1, f1, z1}, 32'h04);
        check("nouse_lat3", {27'd0, n3, s3, p3, f3, z3}, 32'h04);
        next_cycle();
        idle(4);

        // Stall length versus consumer distance
        load_consume(0, c1, c3);
        check("gap0_lat1", c1, 32'd1);
        check("gap0_lat3", c3, 32'd3);
        load_consume(1, c1, c3);
        check("gap1_lat3", c3, 32'd2);
        load_consume(2, c1, c3);
        check("gap2_lat1", c1, 32'd0);
        check("gap2_lat3", c3, 32'd1);
        load_consume(4, c1, c3);
        check("gap4_lat3", c3, 32'd0);

        // x0 never tracked
        set_in(1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0);
        @(negedge clk);
        check("x0_lat3", {27'd0, n3, s3, p3, f3, z3}, 32'h04);
        next_cycle();
        set_in(0, 0, 5'd0, 1, 5'd0, 1, 0, 0);
        @(negedge clk);
        check("x0_after", {27'd0, n3, s3, p3, f3, z3}, 32'h04);
        next_cycle();

        // Freeze holds the scoreboard; branch ignored while frozen
        set_in(1, 5'd9, 0, 0, 0, 0, 0, 0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 5'd9, 1, 0, 0, 1, 1);
            @(negedge clk);
            check("freeze_outs", {27'd0, n3, s3, p3, f3, z3}, 32'h09);
            next_cycle();
        end
        c1 = 0;
        c3 = 0;
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 5'd9, 1, 0, 0, 0, 0);
            @(negedge clk);
            if (s1) c1++;
            if (s3) c3++;
            next_cycle();
        end
        check("post_freeze_lat3", c3, 32'd2);
        check("post_freeze_lat1", c1, 32'd0);

        // LU beats branch, then branch flushes
        set_in(1, 5'd3, 5'd3, 1, 0, 0, 0, 1);
        @(negedge clk);
        check("lu_over_branch", {27'd0, n1, s1, p1, f1, z1}, 32'h18);
        next_cycle();
        set_in(0, 0, 5'd3, 1, 0, 0, 0, 1);
        @(negedge clk);
        check("branch_flush", {27'd0, n1, s1, p1, f1, z1}, 32'h06);
        next_cycle();
        idle(4);

        // Watchdog
        for (int i = 1; i <= 200; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            if (i == 1)   check("wdt_state_first", {31'd0, st1}, 32'd0);
            if (i == 2)   check("wdt_state_frozen", {31'd0, st1}, 32'd1);
            if (i == 200) check("wdt_before_limit", {31'd0, t1}, 32'd0);
            next_cycle();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("wdt_timeout", {31'd0, t1}, 32'd1);
        check("wdt_released", {27'd0, n1, s1, p1, f1, z1}, 32'h04);
        next_cycle();
        idle(3);
        @(negedge clk);
        check("wdt_sticky", {31'd0, t3}, 32'd1);
        next_cycle();

        // Reset mid-stall
        set_in(1, 5'd4, 5'd4, 1, 0, 0, 1, 0);
        next_cycle();
        next_cycle();
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_outs1", {27'd0, n1, s1, p1, f1, z1}, 32'h04);
        check("rst_mid_outs3", {27'd0, n3, s3, p3, f3, z3}, 32'h04);
        check("rst_mid_timeout", {31'd0, t1}, 32'd0);
        check("rst_mid_state", {31'd0, st3}, 32'd0);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised load-use and pipeline-freeze controller for the 5-stage RISC-V core. It sits beside the ID stage and drives the PC, the IF/ID register and the ID/EX bubble mux.
- It generalises single-cycle load-use detection to configurable load latency through a per-register countdown scoreboard.
- It adds x0 exclusion, operand-use qualification, a data-memory busy freeze, IF/ID flush arbitration and a freeze watchdog.

Parameters:
- REG_AW, 5: register address width; scoreboard holds 2**REG_AW entries.
- LOAD_LAT, 1: cycles after MEM entry before load data is forwardable. Range 1..8; 1 gives classic one-bubble behaviour.
- WDT_W, 8: width of the freeze watchdog counter.
- WDT_LIMIT, 200: consecutive busy cycles that trigger timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- RS1addr_i  in  REG_AW  ID rs1
- RS2addr_i  in  REG_AW  ID rs2
- RS1use_i  in  1  ID instruction reads rs1
- RS2use_i  in  1  ID instruction reads rs2
- EX_MemRead_i  in  1  load in EX
- EX_RDaddr_i  in  REG_AW  EX destination
- MemBusy_i  in  1  data memory not ready; the whole pipeline must hold
- BranchTaken_i  in  1  branch resolved taken in ID
- NoOp_o  out  1  insert bubble into ID/EX
- Stall_o  out  1  hold IF/ID
- PCWrite_o  out  1  PC update enable
- Flush_o  out  1  clear IF/ID
- Freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- Timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_i low, any time): all scoreboard entries 0, state RUN, watchdog 0, Timeout_o 0. Outputs are combinational; with no hazard inputs they read NoOp 0, Stall 0, PCWrite 1, Flush 0, Freeze 0.
- Match rule: an operand rsN hits when RSNuse_i=1, rsN!=0, and either of these holds:
  - EX_MemRead_i=1 and EX_RDaddr_i==rsN, or
  - scoreboard[rsN]!=0.
  - LU = hit on rs1 or hit on rs2.
- Scoreboard update, only on advancing cycles (Freeze_o=0):
  - All nonzero entries decrement by 1.
  - Then, if EX_MemRead_i=1 and EX_RDaddr_i!=0, scoreboard[EX_RDaddr_i] := LOAD_LAT-1. The set wins over the decrement for the same entry.
  - A bubble (NoOp) does not block the set, because the EX load still advances.
- While Freeze_o=1, the scoreboard holds.
- FSM states:
  - RUN: MemBusy_i=1 moves to FREEZE.
  - FREEZE: Freeze_o=1, Stall_o=1, PCWrite_o=0, NoOp_o=0, Flush_o=0. MemBusy_i=0 returns to RUN.
  - Freeze_o is combinational on MemBusy_i, so the first busy cycle freezes in RUN too.
- Priority within one cycle, highest first:
  1. MemBusy: freeze.
  2. LU: NoOp=1, Stall=1, PCWrite=0, Flush=0. BranchTaken_i is ignored because the operands are stale.
  3. BranchTaken: Flush=1, PCWrite=1, Stall=0, NoOp=0.
  4. Otherwise: PCWrite=1 and all other outputs 0.
- Watchdog: counts consecutive FREEZE cycles, saturating at 2**WDT_W-1 and clearing in RUN. Reaching WDT_LIMIT sets Timeout_o, which stays set until reset.
- LOAD_LAT=1: scoreboard never nonzero, so behaviour is exactly one-bubble EX-compare detection.
- Back-to-back loads to the same rd reload the entry; the last write wins.
- A load with rd=x0 is never tracked or matched.
- Reset asserted mid-stall releases the pipeline immediately.

Optional Feature:
- HAZ_PERF_EN defined: adds outputs LuStallCnt_o[31:0], FreezeCnt_o[31:0] and FlushCnt_o[31:0].
  - Each increments once per cycle its condition wins priority and wraps at 2**32.
  - All reset to 0.
- Undefined: the ports and counters are absent; core behaviour is identical.

Decomposition:
- Shared package hazard_pkg:
  - FSM state encoding (RUN=1'b0, FREEZE=1'b1).
  - Scoreboard counter width CNT_W = clog2(LOAD_LAT)+1.
  - Constant REG_ZERO.
- One sub-module hazard_scoreboard:
  - Per-register countdown array with set/decrement/hold.
  - Read ports for rs1/rs2 returning a nonzero flag.
- The top holds the FSM, priority logic and watchdog.

Test Plan:
- LOAD_LAT=1, EX load rd=5, ID rs1=5 use=1 -> exactly 1 cycle NoOp=1/Stall=1/PCWrite=0, then clear. Same with rs1=5 use=0 -> no stall.
- LOAD_LAT=3, load rd=7 followed by consumer rs2=7 -> 3 stall cycles total. Consumer arriving 2 cycles after the load -> 1 stall. Consumer arriving 4 cycles after -> 0 stalls.
- Load rd=0 with consumer rs1=0 -> no stall; scoreboard[0] stays 0.
- MemBusy_i high 4 cycles while scoreboard[9]=2 -> Freeze_o=1 for 4 cycles, then entry still 2 and decrements after release. Simultaneous BranchTaken_i gives Flush_o=0 while frozen.
- LU and BranchTaken_i in the same cycle -> stall and Flush_o=0. Next cycle, with no LU and BranchTaken_i=1 -> Flush_o=1, PCWrite_o=1.
- MemBusy_i held 200 cycles with WDT_LIMIT=200 -> Timeout_o rises on cycle 200 and stays high after busy drops. Mid-sequence rst_i low -> all outputs at reset values, Timeout_o=0.
